// File: rtl/micro_exec_seq.sv
// rtl/micro_exec_seq.sv - micro command execution sequencer
// Runs ALU add, optional store, regfile writeback and next-PC commit for one instruction at a time.
module micro_exec_seq #(
    parameter int XLEN      = 32,
    parameter int MICRO_LEN = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MICRO_LEN-1:0] micro_cmd,
    input  logic                 ebreak,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rs1_val,
    input  logic [XLEN-1:0]      rs2_val,
    input  logic [XLEN-1:0]      imm,
    input  logic [4:0]           rd_addr,
    output logic                 mem_wen,
    output logic [XLEN-1:0]      mem_waddr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_wmask,
    input  logic                 mem_ready,
    output logic                 reg_wen,
    output logic [4:0]           reg_waddr,
    output logic [XLEN-1:0]      reg_wdata,
    output logic                 pc_next_valid,
    output logic [XLEN-1:0]      pc_next,
    output logic                 halt,
    output logic                 err
);

    localparam int STRB_W = XLEN / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_STORE,
        S_COMMIT,
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic            regen_q, pcjen_q, pcren_q;
    logic [1:0]      mwen_q, mren_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, sum_q;
    logic [4:0]      rd_q;
    logic            err_q;

    logic            accept;
    logic            err_set;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] link;
    logic            misaligned;
    logic [STRB_W-1:0] base_mask;

    // imm_type only matters upstream where the immediate is formed
    logic unused_imm_type;
    assign unused_imm_type = &{1'b0, micro_cmd[2:0]};

    assign sum  = (pcren_q ? pc_q : rs1_q) + imm_q;
    assign link = pc_q + XLEN'(4);
    assign misaligned = ((mwen_q == 2'b10) && sum[0]) ||
                        ((mwen_q == 2'b11) && (sum[1:0] != 2'b00));

    always_comb begin
        case (mwen_q)
            2'b01:   base_mask = STRB_W'(4'b0001);
            2'b10:   base_mask = STRB_W'(4'b0011);
            2'b11:   base_mask = STRB_W'(4'b1111);
            default: base_mask = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        err_set       = 1'b0;
        in_ready      = 1'b0;
        mem_wen       = 1'b0;
        mem_waddr     = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        reg_wen       = 1'b0;
        reg_waddr     = '0;
        reg_wdata     = '0;
        pc_next_valid = 1'b0;
        pc_next       = '0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ebreak ? S_HALT : S_EXEC;
                end
            end
            S_EXEC: begin
                // Faulting instructions halt before any store or commit is visible
                if ((mren_q != 2'b00) || ((mwen_q != 2'b00) && misaligned)) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else if (mwen_q != 2'b00) begin
                    state_d = S_STORE;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_STORE: begin
                mem_wen   = 1'b1;
                mem_waddr = {sum_q[XLEN-1:2], 2'b00};
                mem_wdata = rs2_q << {sum_q[1:0], 3'b000};
                mem_wmask = base_mask << sum_q[1:0];
                if (mem_ready) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                reg_wen       = regen_q && (rd_q != 5'd0);
                reg_waddr     = rd_q;
                reg_wdata     = pcjen_q ? link : sum_q;
                pc_next_valid = 1'b1;
                pc_next       = !pcjen_q ? link :
                                (pcren_q ? sum_q : {sum_q[XLEN-1:1], 1'b0});
                state_d       = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign halt = (state_q == S_HALT);
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            regen_q <= 1'b0;
            pcjen_q <= 1'b0;
            pcren_q <= 1'b0;
            mwen_q  <= 2'b00;
            mren_q  <= 2'b00;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                regen_q <= micro_cmd[9];
                pcjen_q <= micro_cmd[8];
                pcren_q <= micro_cmd[7];
                mwen_q  <= micro_cmd[6:5];
                mren_q  <= micro_cmd[4:3];
                pc_q    <= pc;
                rs1_q   <= rs1_val;
                rs2_q   <= rs2_val;
                imm_q   <= imm;
                rd_q    <= rd_addr;
            end
            if (state_q == S_EXEC) begin
                sum_q <= sum;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_micro_exec_seq.sv
// tb/tb_micro_exec_seq.sv - self-checking bench for micro_exec_seq
// Directed spec examples followed by random instructions checked against a transaction-level model.
module tb_micro_exec_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  micro_cmd;
    logic        ebreak;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [4:0]  rd_addr;
    logic        mem_wen;
    logic [31:0] mem_waddr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        pc_next_valid;
    logic [31:0] pc_next;
    logic        halt;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_wdata, last_pc_next;

    always #5 clk = ~clk;

    micro_exec_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .micro_cmd(micro_cmd), .ebreak(ebreak), .pc(pc), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .imm(imm), .rd_addr(rd_addr), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .pc_next_valid(pc_next_valid), .pc_next(pc_next),
        .halt(halt), .err(err)
    );

    typedef struct {
        bit          is_err;
        bit          is_store;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          reg_wen;
        logic [31:0] reg_wdata;
        logic [31:0] pc_next;
    } exp_t;

    function automatic exp_t model(input logic [9:0] cmd, input logic [31:0] p, r1, r2, im);
        exp_t        e;
        logic [31:0] sum, link, nbytes, off;
        logic [63:0] wide;
        sum    = (cmd[7] ? p : r1) + im;
        link   = p + 32'd4;
        nbytes = (cmd[6:5] == 2'd3) ? 32'd4 : 32'(cmd[6:5]);
        off    = sum % 32'd4;
        e.is_err    = (cmd[4:3] != 2'd0) || ((nbytes != 0) && ((sum % nbytes) != 0));
        e.is_store  = (nbytes != 0) && !e.is_err;
        e.waddr     = sum - off;
        wide        = {32'd0, r2} * (64'd1 << (8 * off));
        e.wdata     = wide[31:0];
        e.wmask     = 4'(((32'd1 << nbytes) - 32'd1) << off);
        e.reg_wen   = cmd[9];
        e.reg_wdata = cmd[8] ? link : sum;
        e.pc_next   = !cmd[8] ? link : (cmd[7] ? sum : sum - (sum % 32'd2));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    // Entered in an IDLE cycle; leaves in the following IDLE cycle (or halted)
    task automatic run_txn(input logic [9:0] cmd, input logic eb, input logic [31:0] p, r1, r2, im,
                           input logic [4:0] rd, input int wt, output bit halted);
        exp_t e;
        e = model(cmd, p, r1, r2, im);
        if (rd == 5'd0) e.reg_wen = 1'b0;
        halted = 1'b0;
        chk("accept_ready", 32'(in_ready), 32'd1);
        micro_cmd = cmd; ebreak = eb; pc = p; rs1_val = r1; rs2_val = r2; imm = im; rd_addr = rd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        micro_cmd = 10'($urandom); ebreak = 1'b0; pc = $urandom; rs1_val = $urandom;
        rs2_val = $urandom; imm = $urandom; rd_addr = 5'($urandom);
        chk("t1_ready", 32'(in_ready), 32'd0);
        chk("t1_reg_wen", 32'(reg_wen), 32'd0);
        chk("t1_mem_wen", 32'(mem_wen), 32'd0);
        if (eb) begin
            chk("eb_halt", 32'(halt), 32'd1);
            chk("eb_err", 32'(err), 32'd0);
            in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("eb_halt_hold", 32'(halt), 32'd1);
                chk("eb_ready", 32'(in_ready), 32'd0);
                chk("eb_no_write", 32'({reg_wen, mem_wen, pc_next_valid}), 32'd0);
            end
            in_valid = 1'b0;
            halted = 1'b1;
            return;
        end
        chk("t1_pc_valid", 32'(pc_next_valid), 32'd0);
        step();
        if (e.is_err) begin
            for (int i = 0; i < 3; i++) begin
                chk("err_flag", 32'(err), 32'd1);
                chk("err_halt", 32'(halt), 32'd1);
                chk("err_ready", 32'(in_ready), 32'd0);
                chk("err_no_write", 32'({reg_wen, mem_wen, pc_next_valid}), 32'd0);
                step();
            end
            halted = 1'b1;
            return;
        end
        if (e.is_store) begin
            for (int i = 0; i <= wt; i++) begin
                chk("st_wen", 32'(mem_wen), 32'd1);
                chk("st_addr", mem_waddr, e.waddr);
                chk("st_data", mem_wdata, e.wdata);
                chk("st_mask", 32'(mem_wmask), 32'(e.wmask));
                chk("st_no_commit", 32'(pc_next_valid), 32'd0);
                mem_ready = (i == wt);
                in_valid = 1'($urandom);
                step();
            end
            mem_ready = 1'b0;
        end
        chk("c_pc_valid", 32'(pc_next_valid), 32'd1);
        chk("c_pc_next", pc_next, e.pc_next);
        chk("c_reg_wen", 32'(reg_wen), 32'(e.reg_wen));
        chk("c_mem_wen", 32'(mem_wen), 32'd0);
        if (e.reg_wen) begin
            chk("c_waddr", 32'(reg_waddr), 32'(rd));
            chk("c_wdata", reg_wdata, e.reg_wdata);
        end
        last_wdata = reg_wdata;
        last_pc_next = pc_next;
        in_valid = 1'($urandom);
        step();
        in_valid = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_pc_valid", 32'(pc_next_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [9:0]  c;
        logic        eb;
        rst = 1'b1; in_valid = 1'b0; micro_cmd = '0; ebreak = 1'b0; pc = '0; rs1_val = '0;
        rs2_val = '0; imm = '0; rd_addr = '0; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_outs", 32'({mem_wen, reg_wen, pc_next_valid, halt, err}), 32'd0);
        chk("reset_waddr", mem_waddr, 32'd0);
        chk("reset_pc_next", pc_next, 32'd0);

        run_txn(10'b1000000001, 1'b0, 32'h0000_0200, 32'd5, 32'd0, -32'sd3, 5'd7, 0, h);
        chk("addi_wdata", last_wdata, 32'd2);
        chk("addi_pc_next", last_pc_next, 32'h0000_0204);
        run_txn(10'b1110000111, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 32'h10, 5'd1, 0, h);
        chk("jal_wdata", last_wdata, 32'h8000_0004);
        chk("jal_pc_next", last_pc_next, 32'h8000_0010);
        run_txn(10'b1100000000, 1'b0, 32'h0000_0040, 32'h1003, 32'd0, 32'd0, 5'd5, 0, h);
        chk("jalr_pc_next", last_pc_next, 32'h0000_1002);
        run_txn(10'b1010000100, 1'b0, 32'h0000_3000, 32'd0, 32'd0, 32'h1000, 5'd0, 0, h);
        run_txn(10'b0001100010, 1'b0, 32'h0000_0300, 32'h100, 32'hDEAD_BEEF, 32'd4, 5'd9, 3, h);
        run_txn(10'b0000100010, 1'b0, 32'h0000_0304, 32'h102, 32'h0000_00AB, 32'd0, 5'd0, 1, h);
        run_txn(10'b0001100010, 1'b0, 32'h0000_0308, 32'h100, 32'h1234_5678, 32'd2, 5'd0, 0, h);
        do_reset();
        run_txn(10'b1000000001, 1'b1, 32'h0000_0400, 32'd1, 32'd2, 32'd3, 5'd4, 0, h);
        do_reset();

        // Reset while a store is waiting for mem_ready
        micro_cmd = 10'b0001100010; ebreak = 1'b0; pc = 32'h500; rs1_val = 32'h200;
        rs2_val = 32'h55AA_55AA; imm = 32'd0; rd_addr = 5'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("rst_st_wen", 32'(mem_wen), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_st_wen_drop", 32'(mem_wen), 32'd0);
        chk("rst_st_ready", 32'(in_ready), 32'd1);
        run_txn(10'b1000000001, 1'b0, 32'h0000_0600, 32'd5, 32'd0, -32'sd3, 5'd7, 0, h);
        chk("post_rst_addi", last_wdata, 32'd2);

        for (int k = 0; k < 60; k++) begin
            c[9]   = 1'($urandom);
            c[8]   = 1'($urandom);
            c[7]   = 1'($urandom);
            c[6:5] = ($urandom % 2 == 0) ? 2'd0 : 2'($urandom);
            c[4:3] = ($urandom % 10 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            c[2:0] = 3'($urandom);
            eb     = ($urandom % 16 == 0);
            run_txn(c, eb, $urandom, $urandom & 32'h0000_FFFF, $urandom,
                    32'($urandom_range(0, 64)) - 32'd32, 5'($urandom), int'($urandom % 4), h);
            if (h) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
